slc3_control_fsm: RTL and testbench
===================================

// Module: slc3_control_fsm
// PURPOSE
//  Moore control FSM (ISDU) for the SLC-3 datapath. Sits directly upstream of the ALU and datapath.
//  Decodes the IR opcode and sequences fetch, decode, execute and memory wait states.
//  Drives every load enable, bus gate, mux select, ALUK code and SRAM strobe, one state per cycle.
// PARAMETERS
//  MEM_WAIT  2  cycles Mem_OE/Mem_WE is held per SRAM access (>=1)
// PORTS
//  Clk        input   1  system clock, rising edge
//  Reset      input   1  synchronous, active-high
//  Run        input   1  leave HALTED and start fetching
//  Continue   input   1  release PAUSE (level, two-phase)
//  Opcode     input   4  IR[15:12]
//  IR_5       input   1  IR[5], imm/reg select (passed to SR2MUX)
//  IR_11      input   1  IR[11], JSR vs JSRR
//  BEN        input   1  registered branch enable
//  LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED  output 1 each  register loads
//  GatePC,GateMDR,GateALU,GateMARMUX  output 1 each  bus drivers (at most one high)
//  PCMUX      output  2  00 PC+1, 01 bus, 10 address adder
//  ADDR2MUX   output  2  00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0])
//  ALUK       output  2  11 ADD, 01 AND, 10 NOT, 00 PASS SR1
//  ADDR1MUX   output  1  0 PC, 1 SR1
//  DRMUX      output  1  0 IR[11:9], 1 R7
//  SR1MUX     output  1  0 IR[11:9], 1 IR[8:6]
//  SR2MUX     output  1  equals IR_5 in every state
//  Mem_OE, Mem_WE  output 1 each  SRAM read/write strobes (active-high)
// BEHAVIOUR
//  - Outputs are decoded from state only. Every output defaults to 0 except SR2MUX.
//  - Reset: state=HALTED, wait counter=0, all outputs 0. Reset has priority over everything, including mid-access.
//  - HALTED: stay while Run=0. Run=1 -> FETCH1. Run is ignored in all other states.
//  - Fetch path:
//    FETCH1: GatePC, LD_MAR, LD_PC, PCMUX=00
//    FETCH2: Mem_OE for MEM_WAIT cycles; LD_MDR only on the last cycle
//    FETCH3: GateMDR, LD_IR
//    DECODE: LD_BEN
//  - Dispatch from DECODE on Opcode:
//    0001 ADD / 0101 AND / 1001 NOT: one state, then FETCH1.
//      Drives SR1MUX=1, DRMUX=0, GateALU, LD_REG, LD_CC; ALUK=11/01/10.
//    0000 BR: BR_TAKEN if BEN=1, else FETCH1.
//      BR_TAKEN: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC.
//    1100 JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
//    0100 JSR1: GatePC, DRMUX=1, LD_REG.
//      JSR2 if IR_11=1: ADDR1MUX=0, ADDR2MUX=11.
//      JSR2 if IR_11=0: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00.
//      JSR2 always: PCMUX=10, LD_PC.
//    0110 LDR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
//      LDR2: read wait, same as FETCH2.
//      LDR3: GateMDR, DRMUX=0, LD_REG, LD_CC.
//    0111 STR1: same as LDR1.
//      STR2: SR1MUX=0, ALUK=00, GateALU, LD_MDR.
//      STR3: Mem_WE for MEM_WAIT cycles, Mem_OE=0.
//    1101 PAUSE1: LD_LED; stay until Continue=1.
//      PAUSE2: stay until Continue=0, then FETCH1.
//    Any other opcode: DECODE -> FETCH1 with no side effects.
//  - Wait counter: cleared on entry to any wait state; counts 0..MEM_WAIT-1; exits at MEM_WAIT-1.
//  - Latency: ALU-class instruction = MEM_WAIT+4 cycles, FETCH1 to FETCH1.
// STRUCTURE
//  - slc3_pkg: state_t enum, opcode localparams, ALUK/PCMUX/ADDR2MUX encodings, shared with ALU/datapath.
//  - Sub-module slc3_wait_ctr: clear, enable, done; parameter MEM_WAIT.
//  - Two processes: registered state/counter, combinational next-state plus outputs.
// TESTING (MEM_WAIT=2)
//  1. Reset, Run pulse, Opcode=0001 -> FETCH1,FETCH2x2,FETCH3,DECODE,ADD with ALUK=11,LD_REG=LD_CC=1; FETCH1 at cycle 7.
//  2. Opcode=0000: BEN=0 -> FETCH1 after DECODE, LD_PC=0. BEN=1 -> one cycle PCMUX=10,ADDR2MUX=10,LD_PC=1.
//  3. Opcode=0111 -> Mem_WE=1 exactly 2 cycles, Mem_OE=0 throughout, STR2 shows ALUK=00,LD_MDR=1.
//  4. Opcode=1101, Continue=0 for 10 cycles -> stays PAUSE1 with LD_LED=1. Continue=1 -> PAUSE2. Continue=0 -> FETCH1.
//  5. Reset high during first LDR2 cycle -> next cycle all outputs 0, HALTED; no fetch until Run=1.
//  6. Opcode=1111 -> DECODE then FETCH1. LD_REG, LD_PC, Mem_WE never asserted.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared SLC-3 encodings: control states, opcodes and datapath mux/ALU codes.
// The ALU and datapath blocks use the same definitions.
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_PASS = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_ADD  = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // States that hold an SRAM strobe for MEM_WAIT cycles.
    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/slc3_wait_ctr.sv
// SRAM access timer: counts 0..MEM_WAIT-1 while enabled, done on the last count.
module slc3_wait_ctr #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);
    localparam int W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    logic [W-1:0] count;

    assign done = (count == W'(MEM_WAIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (en)
            count <= done ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 ISDU: Moore control FSM sequencing fetch/decode/execute and SRAM waits.
// Outputs decode from state only (plus the IR bits that steer SR2MUX and JSR2).
module slc3_control_fsm
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       Mem_OE,
    output logic       Mem_WE
);
    state_t state, next_state;
    logic   in_wait, wait_done;

    assign in_wait = is_wait(state);

    // Wait states are never back to back, so holding the counter clear
    // outside them is the same as clearing on entry.
    slc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (Clk),
        .reset (Reset),
        .clear (!in_wait),
        .en    (in_wait),
        .done  (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_HALTED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = PCMUX_INC; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_PASS;
        ADDR1MUX = 1'b0; DRMUX = 1'b0; SR1MUX = 1'b0;
        SR2MUX = IR_5;
        Mem_OE = 1'b0; Mem_WE = 1'b0;

        case (state)
            S_HALTED: if (Run) next_state = S_FETCH1;
            S_FETCH1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC;
                next_state = S_FETCH2;
            end
            S_FETCH2: begin
                Mem_OE = 1'b1; LD_MDR = wait_done;
                if (wait_done) next_state = S_FETCH3;
            end
            S_FETCH3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   next_state = S_ADD;
                    OP_AND:   next_state = S_AND;
                    OP_NOT:   next_state = S_NOT;
                    OP_BR:    next_state = BEN ? S_BR_TAKEN : S_FETCH1;
                    OP_JMP:   next_state = S_JMP;
                    OP_JSR:   next_state = S_JSR1;
                    OP_LDR:   next_state = S_LDR1;
                    OP_STR:   next_state = S_STR1;
                    OP_PAUSE: next_state = S_PAUSE1;
                    default:  next_state = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
                next_state = S_FETCH1;
            end
            S_BR_TAKEN: begin
                ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                next_state = S_FETCH1;
            end
            S_JMP: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                next_state = S_FETCH1;
            end
            S_JSR1: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
                next_state = S_JSR2;
            end
            S_JSR2: begin
                if (IR_11) begin
                    ADDR2MUX = ADDR2_OFF11;
                end else begin
                    SR1MUX = 1'b1; ADDR1MUX = 1'b1;
                end
                PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                next_state = S_FETCH1;
            end
            S_LDR1, S_STR1: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                next_state = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR2: begin
                Mem_OE = 1'b1; LD_MDR = wait_done;
                if (wait_done) next_state = S_LDR3;
            end
            S_LDR3: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                next_state = S_FETCH1;
            end
            S_STR2: begin
                ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
                next_state = S_STR3;
            end
            S_STR3: begin
                Mem_WE = 1'b1;
                if (wait_done) next_state = S_FETCH1;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = S_PAUSE2;
            end
            S_PAUSE2: if (!Continue) next_state = S_FETCH1;
            default: next_state = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Bench for slc3_control_fsm: per-instruction latency/pulse table, randomized
// instruction stream against a micro-op list model, and pause/reset sequences.
module tb_slc3_control_fsm;
    localparam int MW = 2;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic addr1mux, drmux, sr1mux, sr2mux, mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        logic [3:0] op;
        logic ben, ir11;
        int len, n_reg, n_pc, n_we, n_oe;
    } vec_t;

    logic Clk, Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE, Mem_WE;
    ctl_t obs;

    int n_chk = 0, n_pass = 0;
    ctl_t expq[$];

    slc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .ADDR1MUX(ADDR1MUX),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                  ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE, Mem_WE};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input ctl_t want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, obs, want);
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    function automatic ctl_t idle(input logic ir5);
        ctl_t c = '0;
        c.sr2mux = ir5;
        return c;
    endfunction

    function automatic ctl_t fetch1(input logic ir5);
        ctl_t c = idle(ir5);
        c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
        return c;
    endfunction

    // Micro-op list of one instruction, starting at its first fetch cycle.
    task automatic build(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
        ctl_t c;
        expq.delete();
        expq.push_back(fetch1(ir5));
        for (int i = 0; i < MW; i++) begin
            c = idle(ir5); c.mem_oe = 1; c.ld_mdr = (i == MW-1); expq.push_back(c);
        end
        c = idle(ir5); c.gate_mdr = 1; c.ld_ir = 1; expq.push_back(c);
        c = idle(ir5); c.ld_ben = 1; expq.push_back(c);
        c = idle(ir5);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
                c.aluk = (op == 4'b0001) ? 2'b11 : (op == 4'b0101) ? 2'b01 : 2'b10;
                expq.push_back(c);
            end
            4'b0000: if (ben) begin
                c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; expq.push_back(c);
            end
            4'b1100: begin
                c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; expq.push_back(c);
            end
            4'b0100: begin
                c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; expq.push_back(c);
                c = idle(ir5); c.pcmux = 2'b10; c.ld_pc = 1;
                if (ir11) c.addr2mux = 2'b11;
                else begin c.sr1mux = 1; c.addr1mux = 1; end
                expq.push_back(c);
            end
            4'b0110, 4'b0111: begin
                c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
                expq.push_back(c);
                if (op == 4'b0110) begin
                    for (int i = 0; i < MW; i++) begin
                        c = idle(ir5); c.mem_oe = 1; c.ld_mdr = (i == MW-1); expq.push_back(c);
                    end
                    c = idle(ir5); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; expq.push_back(c);
                end else begin
                    c = idle(ir5); c.gate_alu = 1; c.ld_mdr = 1; expq.push_back(c);
                    for (int i = 0; i < MW; i++) begin
                        c = idle(ir5); c.mem_we = 1; expq.push_back(c);
                    end
                end
            end
            default: ;
        endcase
    endtask

    vec_t tbl[12];
    logic [3:0] ops[12] = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0100,
                            4'b0110, 4'b0111, 4'b1111, 4'b0010, 4'b1000, 4'b0011};

    initial begin
        int cyc, nreg, npc, nwe, noe;
        tbl[0]  = '{4'b0001, 0, 0, MW+4,   1, 1, 0,  MW};
        tbl[1]  = '{4'b0101, 0, 0, MW+4,   1, 1, 0,  MW};
        tbl[2]  = '{4'b1001, 1, 1, MW+4,   1, 1, 0,  MW};
        tbl[3]  = '{4'b0000, 0, 0, MW+3,   0, 1, 0,  MW};
        tbl[4]  = '{4'b0000, 1, 0, MW+4,   0, 2, 0,  MW};
        tbl[5]  = '{4'b1100, 0, 0, MW+4,   0, 2, 0,  MW};
        tbl[6]  = '{4'b0100, 0, 1, MW+5,   1, 2, 0,  MW};
        tbl[7]  = '{4'b0100, 0, 0, MW+5,   1, 2, 0,  MW};
        tbl[8]  = '{4'b0110, 0, 0, 2*MW+5, 1, 1, 0,  2*MW};
        tbl[9]  = '{4'b0111, 0, 0, 2*MW+5, 0, 1, MW, MW};
        tbl[10] = '{4'b1111, 1, 1, MW+3,   0, 1, 0,  MW};
        tbl[11] = '{4'b0010, 0, 0, MW+3,   0, 1, 0,  MW};

        Reset = 1; Run = 0; Continue = 0; Opcode = 4'b0001; IR_5 = 0; IR_11 = 0; BEN = 0;
        repeat (2) tick();
        Reset = 0; #1;
        chk_ctl("reset", idle(1'b0));
        repeat (3) tick();
        chk_ctl("halted_no_run", idle(1'b0));
        Run = 1; tick(); Run = 0;
        chk_ctl("run_fetch1", fetch1(1'b0));

        // Latency and pulse counts per instruction, FETCH1 to FETCH1.
        foreach (tbl[k]) begin
            Opcode = tbl[k].op; BEN = tbl[k].ben; IR_11 = tbl[k].ir11; #1;
            cyc = 0; nreg = 0; npc = 0; nwe = 0; noe = 0;
            do begin
                nreg += LD_REG; npc += LD_PC; nwe += Mem_WE; noe += Mem_OE;
                tick(); cyc++;
            end while (!(GatePC && LD_MAR) && cyc < 50);
            chk_int($sformatf("len_%0d", k), cyc, tbl[k].len);
            chk_int($sformatf("ld_reg_%0d", k), nreg, tbl[k].n_reg);
            chk_int($sformatf("ld_pc_%0d", k), npc, tbl[k].n_pc);
            chk_int($sformatf("mem_we_%0d", k), nwe, tbl[k].n_we);
            chk_int($sformatf("mem_oe_%0d", k), noe, tbl[k].n_oe);
            if (cyc >= 50) begin
                $display("FAIL timeout_%0d: got no refetch want FETCH1", k);
                $fatal(1, "bench stalled");
            end
        end

        // Randomized stream, cycle-exact against the micro-op list.
        for (int n = 0; n < 150; n++) begin
            Opcode = ops[$urandom_range(11)];
            IR_5 = 1'($urandom); IR_11 = 1'($urandom); BEN = 1'($urandom);
            Run = 1'($urandom); Continue = 1'($urandom);
            #1;
            build(Opcode, IR_5, IR_11, BEN);
            foreach (expq[i]) begin
                chk_ctl($sformatf("rand_%0d_op%b_c%0d", n, Opcode, i), expq[i]);
                tick();
            end
        end
        Run = 0; Continue = 0; IR_5 = 0; #1;
        chk_ctl("rand_end_fetch1", fetch1(1'b0));

        // Pause: two-phase Continue handshake.
        Opcode = 4'b1101;
        repeat (MW+3) tick();
        for (int i = 0; i < 10; i++) begin
            ctl_t c = idle(1'b0); c.ld_led = 1;
            chk_ctl($sformatf("pause1_%0d", i), c);
            tick();
        end
        Continue = 1; tick();
        chk_ctl("pause2", idle(1'b0));
        tick();
        chk_ctl("pause2_hold", idle(1'b0));
        Continue = 0; tick();
        chk_ctl("pause_exit", fetch1(1'b0));

        // Reset in the first load-wait cycle.
        Opcode = 4'b0110;
        repeat (MW+4) tick();
        begin
            ctl_t c = idle(1'b0); c.mem_oe = 1; c.ld_mdr = (MW == 1);
            chk_ctl("ldr2_first", c);
        end
        Reset = 1; tick(); Reset = 0;
        chk_ctl("reset_mid_ldr", idle(1'b0));
        repeat (5) tick();
        chk_ctl("halted_after_reset", idle(1'b0));
        Run = 1; tick(); Run = 0;
        chk_ctl("refetch_after_reset", fetch1(1'b0));

        // Full load after the reset: wait counter must start clean.
        IR_5 = 1; #1;
        build(4'b0110, 1'b1, IR_11, BEN);
        foreach (expq[i]) begin
            chk_ctl($sformatf("ldr_after_reset_c%0d", i), expq[i]);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
